// File: rtl/kmeans_controller.sv
// Iteration sequencer for the two-centroid kmeans datapath: clears accumulators,
// replays a frame through kmeans, captures new centroids and iterates to convergence.
module kmeans_controller #(
  parameter int MAX_ITERS      = 8,
  parameter int CONV_THRESH    = 2,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                             clk_in,
  input  logic                             rst_n_in,
  input  logic                             go_in,
  input  logic [8:0]                       init_c1_x_in,
  input  logic [8:0]                       init_c2_x_in,
  input  logic [7:0]                       init_c1_y_in,
  input  logic [7:0]                       init_c2_y_in,
  output logic                             frame_req_out,
  input  logic                             pix_valid_in,
  input  logic [8:0]                       pix_x_in,
  input  logic [7:0]                       pix_y_in,
  input  logic                             pix_last_in,
  output logic                             km_valid_out,
  output logic [8:0]                       km_x_out,
  output logic [7:0]                       km_y_out,
  output logic                             km_start_out,
  output logic                             km_rst_coms_out,
  output logic [8:0]                       km_c1_x_out,
  output logic [8:0]                       km_c2_x_out,
  output logic [7:0]                       km_c1_y_out,
  output logic [7:0]                       km_c2_y_out,
  input  logic                             km_valid_in,
  input  logic [8:0]                       km_c1_x_in,
  input  logic [8:0]                       km_c2_x_in,
  input  logic [7:0]                       km_c1_y_in,
  input  logic [7:0]                       km_c2_y_in,
  output logic                             busy_out,
  output logic                             done_out,
  output logic                             timeout_out,
  output logic [$clog2(MAX_ITERS+1)-1:0]   iter_out
);

  localparam int IW = $clog2(MAX_ITERS + 1);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IW-1:0] ITER_MAX   = IW'(MAX_ITERS);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_REQ, S_STREAM, S_TAB, S_WAIT, S_CHECK, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [8:0]    c1x, c2x, n1x, n2x;
  logic [7:0]    c1y, c2y, n1y, n2y;
  logic [IW-1:0] iter, iter_inc;
  logic [TW-1:0] timer;
  logic          timed_out, fwd_valid, start_q;
  logic [8:0]    fwd_x;
  logic [7:0]    fwd_y;
  logic [10:0]   delta;
  logic          converged, last_iter, timer_hit;

  function automatic logic [10:0] absdiff(input logic [8:0] a, input logic [8:0] b);
    logic [8:0] d;
    d = (a >= b) ? (a - b) : (b - a);
    return {2'b00, d};
  endfunction

  // Movement between the captured result and the centroids it was computed from.
  always_comb begin
    delta = absdiff(n1x, c1x) + absdiff({1'b0, n1y}, {1'b0, c1y})
          + absdiff(n2x, c2x) + absdiff({1'b0, n2y}, {1'b0, c2y});
  end

  assign iter_inc  = iter + 1'b1;
  assign converged = (int'(delta) <= CONV_THRESH);
  assign last_iter = (iter_inc == ITER_MAX);
  assign timer_hit = (timer == TIMER_LAST);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= S_IDLE;
    else           state <= state_nxt;
  end

  // pix_valid_in and km_valid_in are plain qualifier strobes with no backpressure:
  // data is taken on any edge where valid is high and the current state accepts it,
  // and is silently dropped otherwise.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (go_in) state_nxt = S_CLEAR;
      S_CLEAR:  state_nxt = S_REQ;
      S_REQ:    state_nxt = S_STREAM;
      S_STREAM: if (pix_valid_in && pix_last_in) state_nxt = S_TAB;
      S_TAB:    state_nxt = S_WAIT;
      S_WAIT: begin
        if (km_valid_in)    state_nxt = S_CHECK;
        else if (timer_hit) state_nxt = S_DONE;
      end
      S_CHECK:  state_nxt = (converged || last_iter) ? S_DONE : S_CLEAR;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      c1x <= '0; c1y <= '0; c2x <= '0; c2y <= '0;
      n1x <= '0; n1y <= '0; n2x <= '0; n2y <= '0;
      iter      <= '0;
      timer     <= '0;
      timed_out <= 1'b0;
      fwd_valid <= 1'b0;
      fwd_x     <= '0;
      fwd_y     <= '0;
      start_q   <= 1'b0;
    end else begin
      fwd_valid <= (state == S_STREAM) && pix_valid_in;
      if ((state == S_STREAM) && pix_valid_in) begin
        fwd_x <= pix_x_in;
        fwd_y <= pix_y_in;
      end
      // Tabulate lags TAB by one cycle so it lands after the last forwarded pixel.
      start_q <= (state == S_TAB);
      case (state)
        S_IDLE: begin
          if (go_in) begin
            c1x <= init_c1_x_in; c1y <= init_c1_y_in;
            c2x <= init_c2_x_in; c2y <= init_c2_y_in;
            iter      <= '0;
            timed_out <= 1'b0;
          end
        end
        S_TAB: timer <= '0;
        S_WAIT: begin
          if (km_valid_in) begin
            n1x <= km_c1_x_in; n1y <= km_c1_y_in;
            n2x <= km_c2_x_in; n2y <= km_c2_y_in;
          end else if (timer_hit) begin
            timed_out <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_CHECK: begin
          c1x <= n1x; c1y <= n1y;
          c2x <= n2x; c2y <= n2y;
          iter <= iter_inc;
        end
        default: ;
      endcase
    end
  end

  assign busy_out        = (state != S_IDLE);
  assign done_out        = (state == S_DONE);
  assign frame_req_out   = (state == S_REQ);
  assign km_rst_coms_out = (state == S_CLEAR);
  assign km_start_out    = start_q;
  assign km_valid_out    = fwd_valid;
  assign km_x_out        = fwd_x;
  assign km_y_out        = fwd_y;
  assign km_c1_x_out     = c1x;
  assign km_c1_y_out     = c1y;
  assign km_c2_x_out     = c2x;
  assign km_c2_y_out     = c2y;
  assign timeout_out     = timed_out;
  assign iter_out        = iter;

endmodule

// File: tb/tb_kmeans_controller.sv
// Bench for kmeans_controller: drives frames and kmeans results, checks sequencing,
// pixel forwarding and final centroids against a high-level iteration model.
module tb_kmeans_controller;

  localparam int MAXI = 3;
  localparam int THR  = 2;
  localparam int TMO  = 16;

  logic       clk_in = 1'b0, rst_n_in = 1'b0, go_in = 1'b0;
  logic [8:0] init_c1_x_in = '0, init_c2_x_in = '0;
  logic [7:0] init_c1_y_in = '0, init_c2_y_in = '0;
  logic       frame_req_out;
  logic       pix_valid_in = 1'b0, pix_last_in = 1'b0;
  logic [8:0] pix_x_in = '0;
  logic [7:0] pix_y_in = '0;
  logic       km_valid_out, km_start_out, km_rst_coms_out;
  logic [8:0] km_x_out, km_c1_x_out, km_c2_x_out;
  logic [7:0] km_y_out, km_c1_y_out, km_c2_y_out;
  logic       km_valid_in = 1'b0;
  logic [8:0] km_c1_x_in = '0, km_c2_x_in = '0;
  logic [7:0] km_c1_y_in = '0, km_c2_y_in = '0;
  logic       busy_out, done_out, timeout_out;
  logic [1:0] iter_out;

  kmeans_controller #(.MAX_ITERS(MAXI), .CONV_THRESH(THR), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .go_in(go_in),
    .init_c1_x_in(init_c1_x_in), .init_c2_x_in(init_c2_x_in),
    .init_c1_y_in(init_c1_y_in), .init_c2_y_in(init_c2_y_in),
    .frame_req_out(frame_req_out),
    .pix_valid_in(pix_valid_in), .pix_x_in(pix_x_in), .pix_y_in(pix_y_in),
    .pix_last_in(pix_last_in),
    .km_valid_out(km_valid_out), .km_x_out(km_x_out), .km_y_out(km_y_out),
    .km_start_out(km_start_out), .km_rst_coms_out(km_rst_coms_out),
    .km_c1_x_out(km_c1_x_out), .km_c2_x_out(km_c2_x_out),
    .km_c1_y_out(km_c1_y_out), .km_c2_y_out(km_c2_y_out),
    .km_valid_in(km_valid_in),
    .km_c1_x_in(km_c1_x_in), .km_c2_x_in(km_c2_x_in),
    .km_c1_y_in(km_c1_y_in), .km_c2_y_in(km_c2_y_in),
    .busy_out(busy_out), .done_out(done_out), .timeout_out(timeout_out),
    .iter_out(iter_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;
  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [59:0] outs;
  assign outs = {frame_req_out, km_valid_out, km_x_out, km_y_out, km_start_out,
                 km_rst_coms_out, km_c1_x_out, km_c2_x_out, km_c1_y_out, km_c2_y_out,
                 busy_out, done_out, timeout_out, iter_out};

  // ---------------- scoreboard / monitor ----------------
  int n_pass = 0, n_total = 0;
  logic [16:0] exp_q[$];
  logic [16:0] exp_pix;
  int fr_cnt = 0, rc_cnt = 0, st_cnt = 0, dn_cnt = 0, fwd_cnt = 0;
  int last_fwd_cyc = 0, last_pix_cyc = 0, ev_cyc = 0;
  logic [8:0] r1x[4], r2x[4];
  logic [7:0] r1y[4], r2y[4];

  initial forever begin
    @(negedge clk_in);
    if (rst_n_in) begin
      if (km_valid_out) begin
        fwd_cnt++;
        last_fwd_cyc = cyc;
        n_total++;
        if (exp_q.size() == 0)
          $display("FAIL pix_fwd: unexpected forward %h/%h at cycle %0d", km_x_out, km_y_out, cyc);
        else begin
          exp_pix = exp_q.pop_front();
          if ({km_x_out, km_y_out} !== exp_pix)
            $display("FAIL pix_fwd: got %h exp %h", {km_x_out, km_y_out}, exp_pix);
          else n_pass++;
        end
      end
      if (km_start_out) begin
        st_cnt++;
        n_total++;
        if (cyc != last_pix_cyc + 2 || last_fwd_cyc != last_pix_cyc + 1 || exp_q.size() != 0)
          $display("FAIL start_timing: start %0d lastfwd %0d exp %0d/%0d pending %0d",
                   cyc, last_fwd_cyc, last_pix_cyc + 2, last_pix_cyc + 1, exp_q.size());
        else n_pass++;
      end
      if (frame_req_out)   fr_cnt++;
      if (km_rst_coms_out) rc_cnt++;
      if (done_out)        dn_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // which: 1 frame_req, 2 km_start, 3 done, 4 done or rst_coms; got 0 on expiry, 5 = rst_coms
  task automatic wait_event(input int which, input int budget, output int got);
    got = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_in);
      if (which == 1 && frame_req_out) got = 1;
      else if (which == 2 && km_start_out) got = 2;
      else if ((which == 3 || which == 4) && done_out) got = 3;
      else if (which == 4 && km_rst_coms_out) got = 5;
      if (got != 0) begin
        ev_cyc = cyc;
        break;
      end
    end
    if (got == 0) begin
      n_total++;
      $display("FAIL wait_%0d: event not seen within %0d cycles", which, budget);
    end
  endtask

  task automatic send_frame(input int npix, input bit gaps, input bit noise);
    for (int i = 0; i < npix; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        pix_valid_in = 1'b0;
        pix_last_in  = 1'($urandom_range(0, 1));
        @(posedge clk_in); #1;
      end
      pix_valid_in = 1'b1;
      pix_x_in     = 9'($urandom);
      pix_y_in     = 8'($urandom);
      pix_last_in  = (i == npix - 1);
      exp_q.push_back({pix_x_in, pix_y_in});
      last_pix_cyc = cyc;
      if (noise && i == 0) begin
        go_in = 1'b1; km_valid_in = 1'b1;
        km_c1_x_in = 9'($urandom); km_c1_y_in = 8'($urandom);
        km_c2_x_in = 9'($urandom); km_c2_y_in = 8'($urandom);
      end
      @(posedge clk_in); #1;
      go_in = 1'b0; km_valid_in = 1'b0;
    end
    pix_valid_in = 1'b0;
    pix_last_in  = 1'b0;
  endtask

  // One complete go..done job; results r*[0..nresp-1] are returned pass by pass.
  task automatic run_job(input logic [8:0] i1x, input logic [7:0] i1y,
                         input logic [8:0] i2x, input logic [7:0] i2y,
                         input int nresp, input int npix, input bit gaps,
                         input bit noise, input bit go_at_done);
    int m[4], r[4];
    int e_iter, e_passes, delta, got, go_cyc, resp_cyc, st_seen, d, exp_fr;
    int fr0, rc0, st0, dn0, fwd0;
    bit e_to;
    m[0] = int'(i1x); m[1] = int'(i1y); m[2] = int'(i2x); m[3] = int'(i2y);
    e_iter = 0; e_passes = 0; e_to = 1'b0;
    forever begin
      e_passes++;
      if (e_passes > nresp) begin e_to = 1'b1; break; end
      r[0] = int'(r1x[e_passes-1]); r[1] = int'(r1y[e_passes-1]);
      r[2] = int'(r2x[e_passes-1]); r[3] = int'(r2y[e_passes-1]);
      delta = 0;
      for (int j = 0; j < 4; j++) delta += iabs(r[j] - m[j]);
      m = r;
      e_iter++;
      if (delta <= THR || e_iter == MAXI) break;
    end

    fr0 = fr_cnt; rc0 = rc_cnt; st0 = st_cnt; dn0 = dn_cnt;
    init_c1_x_in = i1x; init_c1_y_in = i1y; init_c2_x_in = i2x; init_c2_y_in = i2y;
    @(posedge clk_in); #1;
    go_in = 1'b1; go_cyc = cyc;
    @(posedge clk_in); #1;
    go_in = 1'b0;
    @(negedge clk_in);
    n_total++;
    if (timeout_out !== 1'b0 || busy_out !== 1'b1 || iter_out !== 2'd0 ||
        {km_c1_x_out, km_c1_y_out, km_c2_x_out, km_c2_y_out} !== {i1x, i1y, i2x, i2y})
      $display("FAIL go_accept: to %b busy %b iter %0d c %h exp c %h", timeout_out, busy_out,
               iter_out, {km_c1_x_out, km_c1_y_out, km_c2_x_out, km_c2_y_out}, {i1x, i1y, i2x, i2y});
    else n_pass++;

    resp_cyc = 0;
    for (int k = 0; k <= MAXI; k++) begin
      wait_event(1, 12, got);
      if (got == 0) return;
      exp_fr = (k == 0) ? go_cyc + 2 : resp_cyc + 3;
      n_total++;
      if (ev_cyc != exp_fr) $display("FAIL frame_req_cycle: got %0d exp %0d", ev_cyc, exp_fr);
      else n_pass++;
      fwd0 = fwd_cnt;
      @(posedge clk_in); #1;
      send_frame(npix, gaps, noise && k == 0);
      wait_event(2, 6, got);
      if (got == 0) return;
      st_seen = ev_cyc;
      n_total++;
      if (fwd_cnt - fwd0 != npix) $display("FAIL fwd_count: got %0d exp %0d", fwd_cnt - fwd0, npix);
      else n_pass++;
      if (k >= nresp) begin
        wait_event(3, TMO + 8, got);
        if (got == 0) return;
        n_total++;
        if (ev_cyc != st_seen + TMO)
          $display("FAIL timeout_delay: got %0d exp %0d", ev_cyc - st_seen, TMO);
        else n_pass++;
        break;
      end
      @(posedge clk_in); #1;
      d = $urandom_range(0, 3);
      repeat (d) begin
        pix_valid_in = 1'b1; pix_x_in = 9'($urandom); pix_y_in = 8'($urandom);
        pix_last_in = 1'($urandom_range(0, 1));
        @(posedge clk_in); #1;
      end
      pix_valid_in = 1'b0; pix_last_in = 1'b0;
      km_valid_in = 1'b1;
      km_c1_x_in = r1x[k]; km_c1_y_in = r1y[k]; km_c2_x_in = r2x[k]; km_c2_y_in = r2y[k];
      resp_cyc = cyc;
      @(posedge clk_in); #1;
      km_valid_in = 1'b0;
      wait_event(4, 6, got);
      if (got == 0) return;
      n_total++;
      if (ev_cyc != resp_cyc + 2) $display("FAIL result_to_next: got %0d exp %0d", ev_cyc, resp_cyc + 2);
      else n_pass++;
      if (got == 3) break;
    end

    if (go_at_done) begin
      go_in = 1'b1;
      @(posedge clk_in); #1;
      go_in = 1'b0;
      @(negedge clk_in);
      n_total++;
      if (busy_out !== 1'b0) $display("FAIL go_at_done: busy got %b exp 0", busy_out);
      else n_pass++;
    end
    repeat (2) @(negedge clk_in);
    n_total++;
    if (iter_out !== 2'(e_iter) || timeout_out !== e_to || busy_out !== 1'b0)
      $display("FAIL job_status: iter %0d to %b busy %b exp iter %0d to %b busy 0",
               iter_out, timeout_out, busy_out, e_iter, e_to);
    else n_pass++;
    n_total++;
    if ({km_c1_x_out, km_c1_y_out, km_c2_x_out, km_c2_y_out} !==
        {9'(m[0]), 8'(m[1]), 9'(m[2]), 8'(m[3])})
      $display("FAIL job_centroids: got %0d,%0d %0d,%0d exp %0d,%0d %0d,%0d", km_c1_x_out,
               km_c1_y_out, km_c2_x_out, km_c2_y_out, m[0], m[1], m[2], m[3]);
    else n_pass++;
    n_total++;
    if (fr_cnt - fr0 != e_passes || rc_cnt - rc0 != e_passes || st_cnt - st0 != e_passes ||
        dn_cnt - dn0 != 1)
      $display("FAIL job_pulses: req %0d clr %0d start %0d done %0d exp %0d/%0d/%0d/1",
               fr_cnt - fr0, rc_cnt - rc0, st_cnt - st0, dn_cnt - dn0, e_passes, e_passes, e_passes);
    else n_pass++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int got, dn0, fr0;
    rst_n_in = 1'b0;
    repeat (3) @(negedge clk_in);
    n_total++;
    if (outs !== '0) $display("FAIL reset_hold: outputs got %h exp 0", outs); else n_pass++;
    rst_n_in = 1'b1;
    @(negedge clk_in);
    n_total++;
    if (outs !== '0) $display("FAIL reset_release: outputs got %h exp 0", outs); else n_pass++;

    init_c1_x_in = 9'd77; init_c1_y_in = 8'd33; init_c2_x_in = 9'd400; init_c2_y_in = 8'd200;
    @(posedge clk_in); #1; go_in = 1'b1;
    @(posedge clk_in); #1; go_in = 1'b0;
    wait_event(1, 12, got);
    dn0 = dn_cnt; fr0 = fr_cnt;
    @(posedge clk_in); #1;
    repeat (2) begin
      pix_valid_in = 1'b1; pix_x_in = 9'($urandom); pix_y_in = 8'($urandom); pix_last_in = 1'b0;
      exp_q.push_back({pix_x_in, pix_y_in});
      @(posedge clk_in); #1;
    end
    #2 rst_n_in = 1'b0;
    #1;
    n_total++;
    if (outs !== '0) $display("FAIL reset_async: outputs got %h exp 0", outs); else n_pass++;
    pix_valid_in = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    exp_q.delete();
    repeat (10) @(negedge clk_in);
    n_total++;
    if (outs !== '0 || dn_cnt != dn0 || fr_cnt != fr0)
      $display("FAIL reset_abort: outputs %h done %0d req %0d exp 0/0/0", outs, dn_cnt - dn0, fr_cnt - fr0);
    else n_pass++;
  endtask

  task automatic test_converge();
    r1x[0] = 9'd20; r1y[0] = 8'd15; r2x[0] = 9'd290; r2y[0] = 8'd190;
    r1x[1] = 9'd21; r1y[1] = 8'd15; r2x[1] = 9'd290; r2y[1] = 8'd191;
    run_job(9'd10, 8'd10, 9'd300, 8'd200, 2, 3, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_iter_cap();
    for (int k = 0; k < 3; k++) begin
      r1x[k] = 9'(100 + 50 * (k + 1)); r1y[k] = 8'(50 + 50 * (k + 1));
      r2x[k] = 9'(200 + 50 * (k + 1)); r2y[k] = 8'(60 + 50 * (k + 1));
    end
    run_job(9'd100, 8'd50, 9'd200, 8'd60, 3, 2, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_stream_timing();
    r1x[0] = 9'd5; r1y[0] = 8'd6; r2x[0] = 9'd7; r2y[0] = 8'd8;
    run_job(9'd5, 8'd6, 9'd7, 8'd8, 1, 5, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    run_job(9'd123, 8'd45, 9'd67, 8'd89, 0, 2, 1'b0, 1'b0, 1'b0);
    r1x[0] = 9'd123 ^ 9'h100; r1y[0] = 8'd45; r2x[0] = 9'd67; r2y[0] = 8'd89;
    run_job(9'd123, 8'd45, 9'd67, 8'd89, 1, 3, 1'b1, 1'b0, 1'b0);
    r1x[0] = 9'd1; r1y[0] = 8'd2; r2x[0] = 9'd3; r2y[0] = 8'd4;
    run_job(9'd1, 8'd2, 9'd3, 8'd4, 1, 1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_ignored();
    r1x[0] = 9'd300; r1y[0] = 8'd100; r2x[0] = 9'd30; r2y[0] = 8'd10;
    r1x[1] = 9'd300; r1y[1] = 8'd101; r2x[1] = 9'd31; r2y[1] = 8'd10;
    run_job(9'd250, 8'd120, 9'd60, 8'd5, 2, 4, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [8:0] g1x, g2x;
    logic [7:0] g1y, g2y;
    logic [8:0] i1x, i2x;
    logic [7:0] i1y, i2y;
    for (int j = 0; j < 10; j++) begin
      i1x = 9'($urandom); i1y = 8'($urandom); i2x = 9'($urandom); i2y = 8'($urandom);
      g1x = i1x; g1y = i1y; g2x = i2x; g2y = i2y;
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 1) == 1) begin
          g1x = g1x ^ 9'($urandom_range(0, 1));
          g2y = g2y ^ 8'($urandom_range(0, 1));
        end else begin
          g1x = 9'($urandom); g1y = 8'($urandom); g2x = 9'($urandom); g2y = 8'($urandom);
        end
        r1x[k] = g1x; r1y[k] = g1y; r2x[k] = g2x; r2y[k] = g2y;
      end
      run_job(i1x, i1y, i2x, i2y, $urandom_range(1, 3), $urandom_range(1, 6),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_converge();
    test_iter_cap();
    test_stream_timing();
    test_timeout();
    test_ignored();
    test_back_to_back();
    repeat (3) @(negedge clk_in);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
